multicycle_control: RTL and testbench
=====================================

# multicycle_control

Multicycle control FSM for the RV32I core subset (add, sub, and, or, addi, lw, sw, beq, jal). It sequences a shared-memory, single-ALU datapath through one instruction per 3–5 cycles. It takes `op`/`funct3`/`funct7` from the instruction register, `zero` from the ALU and `mem_ready` from unified memory, and drives every datapath mux and write enable. It replaces the single-cycle decoder when the core is built in multicycle configuration.

## Interface
- No parameters.
- `clk`  in  1  rising-edge clock; only clock.
- `reset`  in  1  synchronous, active-high reset.
- `op`  in  7  opcode from the instruction register.
- `funct3`  in  3  from the instruction register.
- `funct7`  in  7  from the instruction register.
- `zero`  in  1  ALU zero flag, combinational from the current ALU result.
- `mem_ready`  in  1  memory completes the access this cycle.
- `PCWrite`  out  1  PC register load enable.
- `AdrSrc`  out  1  memory address: 0 = PC, 1 = Result.
- `MemWrite`  out  1  memory write strobe.
- `IRWrite`  out  1  instruction register and OldPC load enable.
- `ResultSrc`  out  2  result mux: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- `ALUSrcA`  out  2  ALU A mux: 00 = PC, 01 = OldPC, 10 = rd1.
- `ALUSrcB`  out  2  ALU B mux: 00 = rd2, 01 = ImmExt, 10 = 4.
- `ALUControl`  out  3  ALU operation: 010 add, 110 sub, 000 and, 001 or.
- `ImmSrc`  out  2  immediate format: 00 I, 01 S, 10 B, 11 J.
- `RegWrite`  out  1  register file write enable.
- `illegal_op`  out  1  one-cycle pulse when an unsupported opcode is decoded.
- `state`  out  4  current state encoding, for debug.

## Operation
- State register is 4 bits: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, ALUWB=7, EXECI=8, JAL=9, BEQ=10. Codes 11–15 are unreachable; if ever entered, next state is FETCH.
- Outputs are Moore, decoded from `state`, with three exceptions:
  - `PCWrite` = PCUpdate | (Branch & `zero`).
  - `ImmSrc` is decoded combinationally from `op` in every state: 0010011/0000011 → 00, 0100011 → 01, 1100011 → 10, 1101111 → 11, any other opcode → 00.
  - `IRWrite`, `PCUpdate` and `MemWrite` depend on `mem_ready` as stated per state below.
- Every signal not listed for a state is 0. The default `ALUControl` is 010.
- State behaviour and transitions:
  - FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ResultSrc=10, add; IRWrite = PCUpdate = `mem_ready`. Go to DECODE if `mem_ready`, else stay.
  - DECODE: ALUSrcA=01, ALUSrcB=01, add (precomputes the branch target into ALUOut). Next state by `op`:
    - 0000011 / 0100011 → MEMADR
    - 0110011 → EXECR
    - 0010011 → EXECI
    - 1100011 → BEQ
    - 1101111 → JAL
    - any other opcode → FETCH, with `illegal_op`=1 for this cycle.
  - MEMADR: ALUSrcA=10, ALUSrcB=01, add. Go to MEMREAD if `op`=0000011, else MEMWRITE.
  - MEMREAD: AdrSrc=1, ResultSrc=00. Go to MEMWB on `mem_ready`, else hold.
  - MEMWB: ResultSrc=01, RegWrite=1. Go to FETCH.
  - MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1, held for every cycle the state holds. Go to FETCH on `mem_ready`, else hold.
  - EXECR: ALUSrcA=10, ALUSrcB=00; ALUControl from {funct7, funct3}:
    - 0000000/000 → 010
    - 0100000/000 → 110
    - 0000000/111 → 000
    - 0000000/110 → 001
    - anything else → 010
    - Then go to ALUWB.
  - EXECI: ALUSrcA=10, ALUSrcB=01, add. Go to ALUWB.
  - JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCUpdate=1 (PC ← target; ALU computes OldPC+4). Go to ALUWB.
  - ALUWB: ResultSrc=00, RegWrite=1. Go to FETCH.
  - BEQ: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00, Branch=1. Go to FETCH.
- At most one of RegWrite and MemWrite is asserted in any cycle.

## Timing
- Reset:
  - While `reset`=1 at a rising edge, state ← FETCH.
  - While `reset` is high, PCWrite, IRWrite, MemWrite, RegWrite and `illegal_op` are forced to 0 combinationally.
  - The first FETCH is the cycle after `reset` deasserts.
  - A reset asserted mid-instruction (including during a MEMWRITE wait) aborts the instruction; no further enable rises.
- Cycle counts with `mem_ready` held at 1:

  | Instruction | Cycles |
  |---|---|
  | R-type, I-type | 4 |
  | jal | 4 |
  | sw | 4 |
  | lw | 5 |
  | beq | 3 |

  Each cycle `mem_ready` is low in FETCH, MEMREAD or MEMWRITE adds one cycle.
- `zero` is sampled combinationally during BEQ. The PC load occurs at the BEQ→FETCH edge.
- All enables are valid for the whole cycle. The datapath registers load on the rising edge that ends the cycle.

## Test plan
- **Reset mid-instruction:** assert `reset` for 2 cycles during EXECR → `state`=0 the cycle after release; no RegWrite seen.
- **add with memory wait:** FETCH with `mem_ready`=0 for 2 cycles, then `op`=0110011, funct7=0, funct3=000 →
  - FETCH held 3 cycles, IRWrite=1 only in the last;
  - states 0,0,0,1,6,7,0;
  - ALUControl=010 in EXECR; RegWrite=1 only in ALUWB.
- **sub, lw and sw:**
  - sub (funct7=0100000) → ALUControl=110 in EXECR.
  - lw with `mem_ready`=1 → states 0,1,2,3,4; ResultSrc=01 and RegWrite=1 in MEMWB.
  - sw with `mem_ready` low 3 cycles in MEMWRITE → MemWrite=1 for 4 consecutive cycles, ImmSrc=01, then FETCH.
- **beq:** `op`=1100011 → states 0,1,10.
  - With `zero`=1: PCWrite=1 in BEQ, ALUControl=110, ImmSrc=10.
  - With `zero`=0: PCWrite=0 in BEQ.
- **jal:** `op`=1101111 → states 0,1,9,7; PCWrite=1 in JAL; ImmSrc=11; RegWrite=1 in ALUWB.
- **Illegal opcode:** `op`=1110011 → `illegal_op`=1 for exactly the DECODE cycle; next state 0; no write enable asserted.

Source files
------------

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath bundle for the multicycle RV32I core: instruction
// fields and status flow into the controller, mux selects and enables flow out.
//
// Handshake: mem_ready is a completion strobe. An access presented in
// FETCH, MEMREAD or MEMWRITE is held unchanged until a cycle in which
// mem_ready is 1. That cycle completes the access, and the controller leaves
// the waiting state on the rising edge that ends it.
interface multicycle_control_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       zero;
    logic       mem_ready;

    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ALUControl;
    logic [1:0] ImmSrc;
    logic       RegWrite;
    logic       illegal_op;
    logic [3:0] state;

    // The controller drives the datapath controls.
    modport master (
        input  op, funct3, funct7, zero, mem_ready,
        output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA,
               ALUSrcB, ALUControl, ImmSrc, RegWrite, illegal_op, state
    );

    // The datapath and memory supply the instruction fields and status.
    modport slave (
        output op, funct3, funct7, zero, mem_ready,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA,
               ALUSrcB, ALUControl, ImmSrc, RegWrite, illegal_op, state
    );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle control FSM for the RV32I subset (add/sub/and/or/addi/lw/sw/beq/jal).
// Moore outputs decoded from the state register, gated off while reset is high.
module multicycle_control (
    input  logic                 clk,
    input  logic                 reset,
    multicycle_control_if.master bus
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECI    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;

    state_t     r_state;
    state_t     w_next;

    logic       w_pc_update;
    logic       w_branch;
    logic       w_ir_write;
    logic       w_mem_write;
    logic       w_reg_write;
    logic       w_illegal;
    logic       w_adr_src;
    logic [1:0] w_result_src;
    logic [1:0] w_alu_src_a;
    logic [1:0] w_alu_src_b;
    logic [2:0] w_alu_control;
    logic [2:0] w_r_alu_control;
    logic [1:0] w_imm_src;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // R-type operation select; unsupported funct combinations fall back to add.
    always_comb begin
        w_r_alu_control = ALU_ADD;
        case ({bus.funct7, bus.funct3})
            {7'b0000000, 3'b000}: w_r_alu_control = ALU_ADD;
            {7'b0100000, 3'b000}: w_r_alu_control = ALU_SUB;
            {7'b0000000, 3'b111}: w_r_alu_control = ALU_AND;
            {7'b0000000, 3'b110}: w_r_alu_control = ALU_OR;
            default:              w_r_alu_control = ALU_ADD;
        endcase
    end

    always_comb begin
        w_imm_src = 2'b00;
        case (bus.op)
            OP_ITYPE,
            OP_LOAD:   w_imm_src = 2'b00;
            OP_STORE:  w_imm_src = 2'b01;
            OP_BRANCH: w_imm_src = 2'b10;
            OP_JAL:    w_imm_src = 2'b11;
            default:   w_imm_src = 2'b00;
        endcase
    end

    always_comb begin
        w_next        = S_FETCH;
        w_pc_update   = 1'b0;
        w_branch      = 1'b0;
        w_ir_write    = 1'b0;
        w_mem_write   = 1'b0;
        w_reg_write   = 1'b0;
        w_illegal     = 1'b0;
        w_adr_src     = 1'b0;
        w_result_src  = 2'b00;
        w_alu_src_a   = 2'b00;
        w_alu_src_b   = 2'b00;
        w_alu_control = ALU_ADD;

        case (r_state)
            S_FETCH: begin
                w_adr_src    = 1'b0;
                w_alu_src_a  = 2'b00;
                w_alu_src_b  = 2'b10;
                w_result_src = 2'b10;
                w_ir_write   = bus.mem_ready;
                w_pc_update  = bus.mem_ready;
                w_next       = bus.mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                // ALUOut captures OldPC + imm here so BEQ can load it as the target.
                w_alu_src_a = 2'b01;
                w_alu_src_b = 2'b01;
                case (bus.op)
                    OP_LOAD,
                    OP_STORE:  w_next = S_MEMADR;
                    OP_RTYPE:  w_next = S_EXECR;
                    OP_ITYPE:  w_next = S_EXECI;
                    OP_BRANCH: w_next = S_BEQ;
                    OP_JAL:    w_next = S_JAL;
                    default: begin
                        w_next    = S_FETCH;
                        w_illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                w_alu_src_a = 2'b10;
                w_alu_src_b = 2'b01;
                w_next      = (bus.op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                w_adr_src    = 1'b1;
                w_result_src = 2'b00;
                w_next       = bus.mem_ready ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                w_result_src = 2'b01;
                w_reg_write  = 1'b1;
                w_next       = S_FETCH;
            end
            S_MEMWRITE: begin
                // The strobe stays up for the whole wait so memory sees a stable request.
                w_adr_src    = 1'b1;
                w_result_src = 2'b00;
                w_mem_write  = 1'b1;
                w_next       = bus.mem_ready ? S_FETCH : S_MEMWRITE;
            end
            S_EXECR: begin
                w_alu_src_a   = 2'b10;
                w_alu_src_b   = 2'b00;
                w_alu_control = w_r_alu_control;
                w_next        = S_ALUWB;
            end
            S_EXECI: begin
                w_alu_src_a = 2'b10;
                w_alu_src_b = 2'b01;
                w_next      = S_ALUWB;
            end
            S_JAL: begin
                // PC takes the target from ALUOut while the ALU forms the link value OldPC + 4.
                w_alu_src_a  = 2'b01;
                w_alu_src_b  = 2'b10;
                w_result_src = 2'b00;
                w_pc_update  = 1'b1;
                w_next       = S_ALUWB;
            end
            S_ALUWB: begin
                w_result_src = 2'b00;
                w_reg_write  = 1'b1;
                w_next       = S_FETCH;
            end
            S_BEQ: begin
                w_alu_src_a   = 2'b10;
                w_alu_src_b   = 2'b00;
                w_alu_control = ALU_SUB;
                w_result_src  = 2'b00;
                w_branch      = 1'b1;
                w_next        = S_FETCH;
            end
            default: begin
                w_next = S_FETCH;
            end
        endcase
    end

    // Write enables are held low during reset so an aborted instruction leaves no trace.
    assign bus.PCWrite    = ~reset & (w_pc_update | (w_branch & bus.zero));
    assign bus.IRWrite    = ~reset & w_ir_write;
    assign bus.MemWrite   = ~reset & w_mem_write;
    assign bus.RegWrite   = ~reset & w_reg_write;
    assign bus.illegal_op = ~reset & w_illegal;

    assign bus.AdrSrc     = w_adr_src;
    assign bus.ResultSrc  = w_result_src;
    assign bus.ALUSrcA    = w_alu_src_a;
    assign bus.ALUSrcB    = w_alu_src_b;
    assign bus.ALUControl = w_alu_control;
    assign bus.ImmSrc     = w_imm_src;
    assign bus.state      = r_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed scenarios plus random instruction streams,
// compared cycle by cycle against an instruction-level reference model.
module tb_multicycle_control;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    multicycle_control_if bus ();

    multicycle_control dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef enum int {
        K_ADD, K_SUB, K_AND, K_OR, K_RMISC, K_ADDI, K_LW, K_SW, K_BEQ, K_JAL, K_ILL
    } kind_t;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [22:0] exp_q[$];
    bit          mr_q[$];
    bit          rand_mr = 1'b0;
    int          z_mode = 0;
    int          path[$];

    int n_regw, n_memw, n_irw, n_pcw, n_ill, n_fetch;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [22:0] observed();
        return {bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.ResultSrc,
                bus.ALUSrcA, bus.ALUSrcB, bus.ALUControl, bus.ImmSrc,
                bus.RegWrite, bus.illegal_op, bus.state};
    endfunction

    function automatic kind_t classify(input logic [6:0] op, input logic [2:0] f3,
                                       input logic [6:0] f7);
        case (op)
            7'b0110011: begin
                if (f7 == 7'h00 && f3 == 3'd0) return K_ADD;
                if (f7 == 7'h20 && f3 == 3'd0) return K_SUB;
                if (f7 == 7'h00 && f3 == 3'd7) return K_AND;
                if (f7 == 7'h00 && f3 == 3'd6) return K_OR;
                return K_RMISC;
            end
            7'b0010011: return K_ADDI;
            7'b0000011: return K_LW;
            7'b0100011: return K_SW;
            7'b1100011: return K_BEQ;
            7'b1101111: return K_JAL;
            default:    return K_ILL;
        endcase
    endfunction

    // State sequence each instruction walks through, with every memory wait satisfied.
    task automatic build_path(input kind_t k);
        path.delete();
        case (k)
            K_ADDI:  path = '{0, 1, 8, 7};
            K_LW:    path = '{0, 1, 2, 3, 4};
            K_SW:    path = '{0, 1, 2, 5};
            K_BEQ:   path = '{0, 1, 10};
            K_JAL:   path = '{0, 1, 9, 7};
            K_ILL:   path = '{0, 1};
            default: path = '{0, 1, 6, 7};
        endcase
    endtask

    function automatic logic [22:0] model(input int st, input kind_t k, input logic [6:0] op,
                                          input bit mr, input bit z);
        logic pcw = 0, adr = 0, memw = 0, irw = 0, rw = 0, ill = 0;
        logic [1:0] rs = 0, sa = 0, sb = 0, imm;
        logic [2:0] alu = 3'b010;
        logic [3:0] st4 = 4'(st);
        imm = (op == 7'b0100011) ? 2'd1 : (op == 7'b1100011) ? 2'd2 :
              (op == 7'b1101111) ? 2'd3 : 2'd0;
        case (st)
            0:  begin sb = 2; rs = 2; irw = mr; pcw = mr; end
            1:  begin sa = 1; sb = 1; ill = (k == K_ILL); end
            2:  begin sa = 2; sb = 1; end
            3:  begin adr = 1; end
            4:  begin rs = 1; rw = 1; end
            5:  begin adr = 1; memw = 1; end
            6:  begin
                    sa = 2;
                    alu = (k == K_SUB) ? 3'b110 : (k == K_AND) ? 3'b000 :
                          (k == K_OR) ? 3'b001 : 3'b010;
                end
            7:  begin rw = 1; end
            8:  begin sa = 2; sb = 1; end
            9:  begin sa = 1; sb = 2; pcw = 1; end
            10: begin sa = 2; alu = 3'b110; pcw = z; end
            default: ;
        endcase
        return {pcw, adr, memw, irw, rs, sa, sb, alu, imm, rw, ill, st4};
    endfunction

    function automatic bit next_mr();
        if (mr_q.size() > 0) return mr_q.pop_front();
        if (rand_mr) return ($urandom_range(0, 3) != 0);
        return 1'b1;
    endfunction

    // Drives one instruction from its FETCH to its last state; call just before a negedge.
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
        kind_t k;
        int    idx;
        int    guard;
        bit    mr;
        bit    z;
        k = classify(op, f3, f7);
        build_path(k);
        idx = 0;
        guard = 0;
        n_regw = 0; n_memw = 0; n_irw = 0; n_pcw = 0; n_ill = 0; n_fetch = 0;
        while (idx < path.size() && guard < 100) begin
            @(negedge clk);
            if (guard == 0) begin
                bus.op = op;
                bus.funct3 = f3;
                bus.funct7 = f7;
            end
            mr = next_mr();
            z = (z_mode == 1) ? 1'b1 : (z_mode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
            bus.mem_ready = mr;
            bus.zero = z;
            #1;
            exp_q.push_back(model(path[idx], k, op, mr, z));
            check_eq($sformatf("op%02h_st%0d_c%0d", op, path[idx], guard), 32'(observed()),
                     32'(exp_q.pop_front()));
            n_regw  += int'(bus.RegWrite);
            n_memw  += int'(bus.MemWrite);
            n_irw   += int'(bus.IRWrite);
            n_pcw   += int'(bus.PCWrite);
            n_ill   += int'(bus.illegal_op);
            n_fetch += int'(bus.state == 4'd0);
            if (!((path[idx] == 0 || path[idx] == 3 || path[idx] == 5) && !mr)) idx++;
            guard++;
        end
        if (guard >= 100) check_eq("timeout", 32'd0, 32'd1);
    endtask

    initial begin
        bus.op = 7'b0110011;
        bus.funct3 = 3'd0;
        bus.funct7 = 7'd0;
        bus.zero = 1'b0;
        bus.mem_ready = 1'b1;
        reset = 1'b1;

        // Reset state: enables forced low even with mem_ready high in FETCH.
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check_eq("reset_state", 32'(bus.state), 32'd0);
        check_eq("reset_en", {27'd0, bus.PCWrite, bus.IRWrite, bus.MemWrite, bus.RegWrite,
                              bus.illegal_op}, 32'd0);
        bus.mem_ready = 1'b0;
        reset = 1'b0;

        // add with two FETCH wait cycles.
        mr_q = '{0, 0, 1, 1, 1, 1};
        run_instr(7'b0110011, 3'b000, 7'b0000000);
        check_eq("add_fetch_cycles", n_fetch, 3);
        check_eq("add_irwrite", n_irw, 1);
        check_eq("add_regwrite", n_regw, 1);

        // Reset for two cycles during EXECR aborts the add.
        bus.mem_ready = 1'b1;
        @(negedge clk);
        #1 check_eq("abort_fetch", 32'(bus.state), 32'd0);
        @(negedge clk);
        #1 check_eq("abort_decode", 32'(bus.state), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        #1 check_eq("abort_execr", 32'(bus.state), 32'd6);
        check_eq("abort_execr_rw", 32'(bus.RegWrite), 32'd0);
        @(negedge clk);
        #1 check_eq("abort_rst_state", 32'(bus.state), 32'd0);
        check_eq("abort_rst_en", {28'd0, bus.PCWrite, bus.IRWrite, bus.RegWrite,
                                  bus.MemWrite}, 32'd0);
        bus.mem_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1 check_eq("abort_release", 32'(bus.state), 32'd0);
        check_eq("abort_release_rw", 32'(bus.RegWrite), 32'd0);

        // sub, lw and sw.
        run_instr(7'b0110011, 3'b000, 7'b0100000);
        check_eq("sub_regwrite", n_regw, 1);
        run_instr(7'b0000011, 3'b010, 7'd0);
        check_eq("lw_regwrite", n_regw, 1);
        mr_q = '{1, 1, 1, 0, 0, 0, 1};
        run_instr(7'b0100011, 3'b010, 7'd0);
        check_eq("sw_memwrite_cycles", n_memw, 4);
        check_eq("sw_regwrite", n_regw, 0);

        // beq taken and not taken; FETCH contributes one PC load each.
        z_mode = 1;
        run_instr(7'b1100011, 3'b000, 7'd0);
        check_eq("beq_taken_pcw", n_pcw, 2);
        z_mode = 2;
        run_instr(7'b1100011, 3'b000, 7'd0);
        check_eq("beq_not_taken_pcw", n_pcw, 1);
        z_mode = 0;

        run_instr(7'b1101111, 3'b000, 7'd0);
        check_eq("jal_pcw", n_pcw, 2);
        check_eq("jal_regwrite", n_regw, 1);

        run_instr(7'b1110011, 3'b000, 7'd0);
        check_eq("ill_pulse", n_ill, 1);
        check_eq("ill_writes", n_regw + n_memw, 0);

        // Random instruction stream with random memory stalls and zero flag.
        rand_mr = 1'b1;
        for (int i = 0; i < 80; i++) begin
            logic [6:0] op;
            logic [2:0] f3;
            logic [6:0] f7;
            int pick;
            pick = $urandom_range(0, 7);
            f3 = 3'($urandom_range(0, 7));
            f7 = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) :
                 ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
            case (pick)
                0, 7: begin
                    op = 7'b0110011;
                    if ($urandom_range(0, 3) != 0) f3 = ($urandom_range(0, 2) == 0) ? 3'd0 :
                                                        ($urandom_range(0, 1) == 1) ? 3'd7 : 3'd6;
                end
                1: op = 7'b0010011;
                2: op = 7'b0000011;
                3: op = 7'b0100011;
                4: op = 7'b1100011;
                5: op = 7'b1101111;
                default: op = 7'($urandom_range(0, 127));
            endcase
            run_instr(op, f3, f7);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
